// File: rtl/fifo_word_packer_pkg.sv
// Shared widths, keep encodings and flush-state encoding for the halfword-to-word packer.
package fifo_word_packer_pkg;
  localparam int HW_W  = 16;
  localparam int OUT_W = 32;

  localparam logic [1:0] KEEP_FULL = 2'b11;
  localparam logic [1:0] KEEP_LO   = 2'b01;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FL_WAIT = 2'd1,
    FL_EMIT = 2'd2
  } state_t;
endpackage

// File: rtl/fifo_word_packer_stage_buf.sv
// Circular halfword staging buffer: one write per cycle, pop of one or two
// entries, with the two oldest entries always visible at the head.
module halfword_stage_buf
  import fifo_word_packer_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  localparam int PW = $clog2(BUF_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [HW_W-1:0] wr_data,
  input  logic            pop_one,
  input  logic            pop_two,
  output logic [CW-1:0]   occ,
  output logic [HW_W-1:0] head0,
  output logic [HW_W-1:0] head1
);
  logic [HW_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_step;
  logic [CW-1:0]   pop_cnt;
  logic [CW-1:0]   occ_nxt;

  // Pointer widths equal log2(depth), so plain addition wraps modulo depth.
  always_comb begin
    rd_step = '0;
    pop_cnt = '0;
    if (pop_two) begin
      rd_step = PW'(2);
      pop_cnt = CW'(2);
    end else if (pop_one) begin
      rd_step = PW'(1);
      pop_cnt = CW'(1);
    end
    occ_nxt = occ + CW'(wr_en) - pop_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + rd_step;
      occ    <= occ_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PW'(1)];
endmodule

// File: rtl/fifo_word_packer.sv
// Drains a 16-bit FIFO with one-cycle read latency and packs halfword pairs into
// 32-bit words on a valid/ready port; flush emits a trailing odd halfword padded.
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  input  logic             fifo_under,
  input  logic [HW_W-1:0]  fifo_dout,
  output logic             fifo_rd,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_keep,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(BUF_DEPTH);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   outst_nxt;
  logic [CW:0]     inflight;
  logic [HW_W-1:0] head0;
  logic [HW_W-1:0] head1;
  logic            wr_en;
  logic            stray;
  logic            load_en;
  logic            pack_go;
  logic            pad_go;

  // Counting issued-but-unreturned reads against free space keeps the buffer from overflowing.
  assign inflight = {1'b0, occ} + {1'b0, outst};
  assign fifo_rd  = !fifo_empty && (inflight < DEPTH_V) && (state == RUN);
  assign wr_en    = fifo_valid && (outst != '0);
  assign stray    = fifo_valid && (outst == '0);
  assign load_en  = !out_valid || out_ready;
  assign pack_go  = load_en && (occ >= CW'(2));
  assign pad_go   = load_en && (state == FL_EMIT) && (occ == CW'(1));
  assign busy     = (state != RUN) || (occ != '0) || (outst != '0) || out_valid;

  halfword_stage_buf #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (fifo_dout),
    .pop_one (pad_go),
    .pop_two (pack_go),
    .occ     (occ),
    .head0   (head0),
    .head1   (head1)
  );

  always_comb begin
    state_nxt = state;
    outst_nxt = outst + CW'(fifo_rd) - CW'(wr_en);
    unique case (state)
      RUN:     if (flush) state_nxt = FL_WAIT;
      FL_WAIT: if (outst == '0) state_nxt = FL_EMIT;
      FL_EMIT: if ((occ == '0) || pad_go) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      outst <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      outst <= outst_nxt;
      if (fifo_under || stray) err <= 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (load_en) begin
      if (pack_go) begin
        out_data  <= {head1, head0};
        out_keep  <= KEEP_FULL;
        out_valid <= 1'b1;
      end else if (pad_go) begin
        out_data  <= {{(OUT_W-HW_W){1'b0}}, head0};
        out_keep  <= KEEP_LO;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a queue-based FIFO model feeds the DUT, and a
// scoreboard of expected packed words is checked by an independent output monitor.
module tb_fifo_word_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_valid;
  logic        fifo_under;
  logic [15:0] fifo_dout;
  logic        fifo_rd;
  logic        flush;
  logic [31:0] out_data;
  logic [1:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        err;

  fifo_word_packer #(.BUF_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .fifo_under (fifo_under),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int first_rd = -1;
  int first_ov = -1;
  logic [15:0] fq[$];
  logic [15:0] pend[$];
  logic [33:0] exp_q[$];
  bit   force_stray = 1'b0;
  bit   rand_ready = 1'b0;
  logic ready_set = 1'b0;
  bit   hold_chk = 1'b0;
  logic [33:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Reference: halfwords leave the FIFO in push order; every two form a word,
  // and a flush with one halfword left over yields a padded word.
  task automatic push_hw(input logic [15:0] v);
    fq.push_back(v);
    fifo_empty = 1'b0;
    pend.push_back(v);
    if (pend.size() == 2) begin
      exp_q.push_back({pend[1], pend[0], 2'b11});
      pend.delete();
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    if (pend.size() == 1) exp_q.push_back({16'h0000, pend[0], 2'b01});
    pend.delete();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic settle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (fq.size() == 0 && !fifo_valid) done = 1'b1;
    end
    if (!done) timeout_fail(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fq.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) timeout_fail(name);
  endtask

  // FIFO model: a read sampled at an edge returns data just after that edge.
  initial begin
    bit rd_s;
    bit st_s;
    forever begin
      @(posedge clk);
      cyc++;
      rd_s = fifo_rd && rst;
      st_s = force_stray;
      if (rd_s) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      #1;
      if (!rst) begin
        fifo_valid = 1'b0;
      end else if (rd_s && fq.size() > 0) begin
        fifo_dout  = fq.pop_front();
        fifo_valid = 1'b1;
      end else if (st_s) begin
        fifo_dout   = 16'hBEEF;
        fifo_valid  = 1'b1;
        force_stray = 1'b0;
      end else begin
        fifo_valid = 1'b0;
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_set;
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (!rst) begin
      hold_chk = 1'b0;
    end else begin
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (hold_chk) check("hold_stable", {31'd0, out_valid, out_data, out_keep}, {31'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        hold_chk = 1'b0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none", {out_data, out_keep});
        end else begin
          check("word", {30'd0, out_data, out_keep}, {30'd0, exp_q.pop_front()});
        end
      end else if (out_valid) begin
        hold_chk = 1'b1;
        held = {out_data, out_keep};
      end else begin
        hold_chk = 1'b0;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0;
    flush = 1'b0;
    fifo_under = 1'b0;
    fifo_empty = 1'b1;
    fifo_valid = 1'b0;
    fifo_dout = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_keep", out_keep, 0);
    check("rst_err", err, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    ready_set = 1'b1;
    repeat (3) @(negedge clk);

    rd_cnt = 0;
    first_rd = -1;
    first_ov = -1;
    for (int v = 1; v <= 4; v++) push_hw(16'(v));
    wait_drain("basic_drain");
    check("latency", 64'(first_ov - first_rd), 3);
    check("basic_reads", rd_cnt, 4);
    check("basic_busy", busy, 0);

    ready_set = 1'b0;
    repeat (3) @(negedge clk);
    rd_cnt = 0;
    for (int v = 1; v <= 8; v++) push_hw(16'(v));
    repeat (20) @(negedge clk);
    check("bp_fifo_rd", fifo_rd, 0);
    check("bp_reads", rd_cnt, 6);
    check("bp_fifo_nonempty", fifo_empty, 0);
    check("bp_head_word", {out_valid, out_data, out_keep}, {1'b1, 32'h0002_0001, 2'b11});
    ready_set = 1'b1;
    wait_drain("bp_drain");
    check("bp_total_reads", rd_cnt, 8);

    for (int v = 1; v <= 3; v++) push_hw(16'(v));
    settle("flush_settle");
    do_flush();
    wait_drain("flush_drain");
    check("flush_busy", busy, 0);

    force_stray = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_err", err, 1);
    check("stray_dropped", busy, 0);
    repeat (10) @(negedge clk);
    check("stray_err_sticky", err, 1);
    check("stray_no_out", out_valid, 0);

    ready_set = 1'b0;
    repeat (3) @(negedge clk);
    for (int v = 1; v <= 3; v++) push_hw(16'(v));
    settle("rst_mid_settle");
    repeat (3) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    fq.delete();
    pend.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_keep", out_keep, 0);
    check("arst_err", err, 0);
    check("arst_fifo_rd", fifo_rd, 0);
    check("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ready_set = 1'b1;
    repeat (3) @(negedge clk);
    push_hw(16'h0001);
    push_hw(16'h0002);
    wait_drain("post_rst_drain");
    check("post_rst_err", err, 0);
    @(negedge clk);
    fifo_under = 1'b1;
    @(negedge clk);
    fifo_under = 1'b0;
    check("under_err", err, 1);

    rand_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 9);
      for (int k = 0; k < n; k++) begin
        push_hw(16'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      settle("rand_settle");
      if (it % 2 == 1) do_flush();
    end
    settle("rand_final_settle");
    do_flush();
    rand_ready = 1'b0;
    ready_set = 1'b1;
    wait_drain("rand_drain");
    check("rand_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
